// File: rtl/tlul_echo_master_buf_if.sv
// rtl/tlul_echo_master_buf_if.sv - TL-UL A/D channel bundle between the echo master and the UART slave
// Parameters: W data bytes, A address bits, Z size bits, O source bits, I sink bits.
// master modport: drives the A channel and d_ready; slave modport: drives a_ready and the D channel.
interface tlul_echo_master_buf_if #(
    parameter int W = 4,
    parameter int A = 32,
    parameter int Z = 4,
    parameter int O = 5,
    parameter int I = 5
);
    logic [2:0]     a_opcode;
    logic [2:0]     a_param;
    logic [Z-1:0]   a_size;
    logic [O-1:0]   a_source;
    logic [A-1:0]   a_address;
    logic [W-1:0]   a_mask;
    logic [8*W-1:0] a_data;
    logic           a_valid;
    logic           a_ready;

    logic [2:0]     d_opcode;
    logic [1:0]     d_param;
    logic [Z-1:0]   d_size;
    logic [O-1:0]   d_source;
    logic [I-1:0]   d_sink;
    logic [8*W-1:0] d_data;
    logic           d_error;
    logic           d_valid;
    logic           d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid,
        input  d_ready
    );
endinterface

// File: rtl/tlul_echo_master_buf.sv
// rtl/tlul_echo_master_buf.sv - buffered TL-UL echo master: polls UART for bytes, FIFOs them, writes them back
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   bus          TL-UL master side (A channel requests, D channel responses)
//   fifo_level   FIFO occupancy 0..DEPTH
//   rx_count     bytes pushed into the FIFO (wraps)
//   tx_count     bytes acknowledged by the UART transmitter (wraps)
//   proto_err    sticky: response with wrong source or opcode was seen
module tlul_echo_master_buf #(
    parameter int UART_ADDRESS = 127,
    parameter int W            = 4,
    parameter int A            = 32,
    parameter int Z            = 4,
    parameter int O            = 5,
    parameter int I            = 5,
    parameter int DEPTH        = 8,
    parameter int MODE         = 0,
    parameter int SOURCE_ID    = 0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    tlul_echo_master_buf_if.master   bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              rx_count,
    output logic [15:0]              tx_count,
    output logic                     proto_err
);
    localparam int LW = $clog2(DEPTH);
    localparam int L  = UART_ADDRESS % W;

    typedef enum logic [1:0] {ARB, REQ, RSP} state_t;

    state_t        state;
    logic          last_put;   // 1 when the previously completed transaction was a Put
    logic          cur_put;    // kind of the transaction currently in flight
    logic [7:0]    mem [DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;

    logic          put_ok;
    logic          get_ok;
    logic          sel_put;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          bad_rsp;
    logic [7:0]    rx_byte;
    logic [7:0]    head;
    logic          unused;

    function automatic logic [7:0] xform(input logic [7:0] b);
        if (MODE == 1 && b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    assign put_ok   = fifo_level != '0;
    assign get_ok   = fifo_level != (LW+1)'(DEPTH);
    // Alternate when both are possible so neither direction starves.
    assign sel_put  = put_ok && (!get_ok || !last_put);
    assign head     = mem[rd_ptr];

    assign rsp_fire = (state == RSP) && bus.d_valid;
    assign push     = rsp_fire && !cur_put && !bus.d_error;
    assign pop      = rsp_fire &&  cur_put && !bus.d_error;
    assign rx_byte  = xform(bus.d_data[8*L +: 8]);
    assign bad_rsp  = (bus.d_source != O'(SOURCE_ID)) ||
                      (bus.d_opcode != (cur_put ? 3'd0 : 3'd1));

    assign unused   = ^{bus.d_param, bus.d_size, bus.d_sink, bus.d_data};

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= ARB;
            last_put      <= 1'b1;
            cur_put       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            rx_count      <= '0;
            tx_count      <= '0;
            proto_err     <= 1'b0;
            bus.a_opcode  <= '0;
            bus.a_param   <= '0;
            bus.a_size    <= '0;
            bus.a_source  <= '0;
            bus.a_address <= '0;
            bus.a_mask    <= '0;
            bus.a_data    <= '0;
            bus.a_valid   <= 1'b0;
            bus.d_ready   <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (put_ok || get_ok) begin
                        cur_put       <= sel_put;
                        bus.a_opcode  <= sel_put ? 3'd0 : 3'd4;
                        bus.a_param   <= '0;
                        bus.a_size    <= '0;
                        bus.a_source  <= O'(SOURCE_ID);
                        bus.a_address <= A'(UART_ADDRESS);
                        bus.a_mask    <= W'(1) << L;
                        bus.a_data    <= sel_put ? ((8*W)'(head) << (8*L)) : '0;
                        bus.a_valid   <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.a_ready) begin
                        bus.a_valid <= 1'b0;
                        bus.d_ready <= 1'b1;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (bus.d_valid) begin
                        bus.d_ready <= 1'b0;
                        last_put    <= cur_put;
                        state       <= ARB;
                        if (bad_rsp) begin
                            proto_err <= 1'b1;
                        end
                        // push and pop are mutually exclusive: one transaction at a time.
                        if (push) begin
                            wr_ptr     <= wr_ptr + 1'b1;
                            fifo_level <= fifo_level + 1'b1;
                            rx_count   <= rx_count + 16'd1;
                        end
                        if (pop) begin
                            rd_ptr     <= rd_ptr + 1'b1;
                            fifo_level <= fifo_level - 1'b1;
                            tx_count   <= tx_count + 16'd1;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: doc/tlul_echo_master_buf.md
Name: tlul_echo_master_buf

Overview:
- Parametrised successor to the single-byte TL-UL echo master: a TL-UL master that polls the UART slave at UART_ADDRESS for received bytes.
- Received bytes are buffered in a DEPTH-entry FIFO, optionally transformed per MODE, and written back to the UART for transmission.
- Sits between the TL-UL UART slave and the top-level echo wrapper, replacing the unbuffered master.
- Exposes traffic counters and a sticky protocol-error flag.

Parameters:
- UART_ADDRESS, 127, byte address of the UART data register.
- W, 4, data bus width in bytes.
- A, 32, address width.
- Z, 4, size field width.
- O, 5, source ID width.
- I, 5, sink ID width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- MODE, 0, 0 = verbatim echo; 1 = ASCII a-z converted to A-Z, all other bytes unchanged.
- SOURCE_ID, 0, constant value driven on a_source.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- a_opcode  out  3  4 = Get, 0 = PutFullData.
- a_param  out  3  always 0.
- a_size  out  Z  always 0 (1 byte).
- a_source  out  O  SOURCE_ID.
- a_address  out  A  UART_ADDRESS.
- a_mask  out  W  one-hot on lane L = UART_ADDRESS mod W.
- a_data  out  8*W  byte on lane L, zero elsewhere; all zero for Get.
- a_valid  out  1  request valid.
- a_ready  in  1  slave accepts request.
- d_opcode  in  3  1 = AccessAckData, 0 = AccessAck.
- d_param  in  2  ignored.
- d_size  in  Z  ignored.
- d_source  in  O  checked against SOURCE_ID.
- d_sink  in  I  ignored.
- d_data  in  8*W  read byte on lane L.
- d_error  in  1  Get: no byte available. Put: TX busy.
- d_valid  in  1  response valid.
- d_ready  out  1  master accepts response.
- fifo_level  out  log2(DEPTH)+1  current occupancy.
- rx_count  out  16  bytes accepted into the FIFO; wraps.
- tx_count  out  16  bytes successfully transmitted; wraps.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - a_valid = 0, d_ready = 0.
  - FIFO empty; fifo_level, rx_count, tx_count and proto_err all 0.
  - FSM = ARB; last_served = PUT.
  - All A-channel payload outputs are registered and 0.
- Transactions: at most one outstanding at any time.
- FSM states:
  - ARB: select an operation.
    - Put is eligible when the FIFO is non-empty; Get is eligible when the FIFO is not full.
    - If both are eligible, serve the opposite of last_served. If neither is eligible (impossible for DEPTH ≥ 2), stay in ARB.
    - Load the A payload and raise a_valid on the next edge; go to REQ.
  - REQ: hold a_valid and keep the payload stable until a_valid & a_ready is sampled. Then drop a_valid, raise d_ready and go to RSP.
  - RSP: d_ready = 1; wait for d_valid.
    - On d_valid, update last_served, drop d_ready, go to ARB.
    - Minimum request-to-request spacing is 3 cycles.
- Get response handling:
  - d_error = 0: push d_data[8L+:8] into the FIFO after the MODE transform; rx_count += 1.
  - d_error = 1: no push.
- Put payload: the FIFO head byte (peek, not pop).
- Put response handling:
  - d_error = 0: pop the head; tx_count += 1.
  - d_error = 1: no pop; the same byte is retried on the next Put.
- MODE 1 transform: applied at push time, 8'h61..8'h7A minus 8'h20.
- Protocol checks: in RSP, set proto_err sticky if either of these holds:
  - d_source ≠ SOURCE_ID;
  - d_opcode ≠ the expected value (1 after Get, 0 after Put).
  - The response is still consumed and processed normally. Only reset clears proto_err.
- Ignore d_valid outside RSP; d_ready = 0 there.
- Full FIFO: no Get is issued, so no byte can be lost. Empty FIFO: no Put is issued.
- FIFO pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- Counters wrap at 16'hFFFF → 0.
- Reset mid-transaction: all state is abandoned immediately and a_valid drops asynchronously. The slave is reset together with this block.

Test Plan:
- Echo: after reset, slave returns byte 8'h41 with d_error=0 → next request is a Put with a_data[31:24] = 8'h41, a_mask = 4'b1000 (default parameters); tx_count = 1.
- MODE=1: received bytes 8'h61, 8'h7A, 8'h31 → transmitted 8'h41, 8'h5A, 8'h31 in order.
- Backpressure: slave holds a_ready = 0 for 5 cycles → a_valid stays high and a_opcode/a_data remain stable throughout.
- Full FIFO: Put always answered d_error=1, Gets always supply bytes → fifo_level reaches 8 (DEPTH=8), no further Gets issued, rx_count = 8, the same head byte is retried on every Put.
- Protocol error: response d_source = 3 with SOURCE_ID = 0 → proto_err = 1 and stays 1; the byte is still pushed.
- Async reset: RST_N low during REQ with a_valid = 1 → a_valid = 0 before the next CLK edge, and fifo_level, rx_count, tx_count and proto_err are all 0.
